// File: rtl/css_mcu0_dmi_pkg.sv
// Shared types and default sizing for the core-side DMI request path.
package css_mcu0_dmi_pkg;

    localparam int DMI_NUM_CH      = 1;
    localparam int DMI_SYNC_STAGES = 3;
    localparam int DMI_DEPTH       = 4;
    localparam int DMI_ADDR_W      = 7;
    localparam int DMI_DATA_W      = 32;
    localparam int DMI_CH_W        = 1;

    typedef struct packed {
        logic                  we;
        logic [DMI_ADDR_W-1:0] addr;
        logic [DMI_DATA_W-1:0] data;
        logic [DMI_CH_W-1:0]   ch;
    } dmi_req_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/css_mcu0_dmi_req_fifo.sv
// Request queue between the channel arbiter and the core register port.
module css_mcu0_dmi_req_fifo
    import css_mcu0_dmi_pkg::*;
#(
    parameter type T      = dmi_req_t,
    parameter int  DEPTH  = DMI_DEPTH,
    parameter int  NUM_CH = DMI_NUM_CH,
    parameter int  CH_W   = DMI_CH_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  T                  push_req,
    input  logic              pop,
    output T                  head,
    output logic              full,
    output logic              empty,
    output logic [NUM_CH-1:0] ch_occ
);

    localparam int PW = $clog2(DEPTH);

    T            mem_q [DEPTH];
    T            mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;
    logic [PW-1:0] off;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_req;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        ch_occ = '0;
        off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if ({1'b0, off} < count_q) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (mem_q[i].ch == CH_W'(c)) begin
                        ch_occ[c] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/css_mcu0_dmi_req_sync_q.sv
// Synchronizes per-TAP DMI request levels into clk and queues them round-robin.
module css_mcu0_dmi_req_sync_q
    import css_mcu0_dmi_pkg::*;
#(
    parameter int NUM_CH      = DMI_NUM_CH,
    parameter int SYNC_STAGES = DMI_SYNC_STAGES,
    parameter int DEPTH       = DMI_DEPTH,
    parameter int ADDR_W      = DMI_ADDR_W,
    parameter int DATA_W      = DMI_DATA_W,
    parameter int CH_W        = ch_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        rd_en,
    input  logic [NUM_CH-1:0]        wr_en,
    input  logic [NUM_CH*ADDR_W-1:0] wr_addr,
    input  logic [NUM_CH*DATA_W-1:0] wr_data,
    input  logic [NUM_CH-1:0]        overrun_clr,
    output logic                     reg_valid,
    input  logic                     reg_ready,
    output logic                     reg_wr_en,
    output logic [ADDR_W-1:0]        reg_addr,
    output logic [DATA_W-1:0]        reg_wr_data,
    output logic [CH_W-1:0]          reg_ch,
    output logic [NUM_CH-1:0]        ch_busy,
    output logic [NUM_CH-1:0]        ch_overrun
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [CH_W-1:0]   ch;
    } req_t;

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] rd_sync_q, rd_sync_d;
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] wr_sync_q, wr_sync_d;
    logic [NUM_CH-1:0] rd_s, wr_s, req_edge;
    logic [NUM_CH-1:0] prev_q, prev_d;

    logic [NUM_CH-1:0]             pend_q, pend_d;
    logic [NUM_CH-1:0]             pend_we_q, pend_we_d;
    logic [NUM_CH-1:0][ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [NUM_CH-1:0][DATA_W-1:0] pend_data_q, pend_data_d;
    logic [NUM_CH-1:0]             ovr_q, ovr_d;
    logic [CH_W-1:0]               rr_ptr_q, rr_ptr_d;

    logic              gnt_vld;
    logic [CH_W-1:0]   gnt_ch;
    req_t              push_req;
    req_t              head;
    logic              fifo_full, fifo_empty;
    logic [NUM_CH-1:0] ch_occ;
    int                rank, best;

    assign rd_s     = rd_sync_q[SYNC_STAGES-1];
    assign wr_s     = wr_sync_q[SYNC_STAGES-1];
    assign req_edge = (rd_s | wr_s) & ~prev_q;

    always_comb begin
        rd_sync_d = {rd_sync_q[SYNC_STAGES-2:0], rd_en};
        wr_sync_d = {wr_sync_q[SYNC_STAGES-2:0], wr_en};
        prev_d    = rd_s | wr_s;
    end

    // Rank 0 is the channel just above the last grant, wrapping.
    always_comb begin
        best     = NUM_CH;
        rank     = 0;
        gnt_ch   = '0;
        push_req = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            rank = (c + NUM_CH - 1 - int'(rr_ptr_q)) % NUM_CH;
            if (pend_q[c] && rank < best) begin
                best          = rank;
                gnt_ch        = CH_W'(c);
                push_req.we   = pend_we_q[c];
                push_req.addr = pend_addr_q[c];
                push_req.data = pend_data_q[c];
                push_req.ch   = CH_W'(c);
            end
        end
        gnt_vld = (best < NUM_CH) && !fifo_full;
    end

    always_comb begin
        pend_d      = pend_q;
        pend_we_d   = pend_we_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        ovr_d       = ovr_q & ~overrun_clr;
        rr_ptr_d    = rr_ptr_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (req_edge[c]) begin
                if (pend_q[c]) begin
                    ovr_d[c] = 1'b1;
                end else begin
                    pend_d[c]      = 1'b1;
                    pend_we_d[c]   = wr_s[c];
                    pend_addr_d[c] = wr_addr[c*ADDR_W +: ADDR_W];
                    pend_data_d[c] = wr_data[c*DATA_W +: DATA_W];
                end
            end
            if (gnt_vld && gnt_ch == CH_W'(c)) begin
                pend_d[c] = 1'b0;
            end
        end
        if (gnt_vld) begin
            rr_ptr_d = gnt_ch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_sync_q   <= '0;
            wr_sync_q   <= '0;
            prev_q      <= '0;
            pend_q      <= '0;
            pend_we_q   <= '0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            ovr_q       <= '0;
            rr_ptr_q    <= CH_W'(NUM_CH - 1);
        end else begin
            rd_sync_q   <= rd_sync_d;
            wr_sync_q   <= wr_sync_d;
            prev_q      <= prev_d;
            pend_q      <= pend_d;
            pend_we_q   <= pend_we_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            ovr_q       <= ovr_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    css_mcu0_dmi_req_fifo #(
        .T      (req_t),
        .DEPTH  (DEPTH),
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (gnt_vld),
        .push_req (push_req),
        .pop      (reg_valid & reg_ready),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .ch_occ   (ch_occ)
    );

    assign reg_valid   = ~fifo_empty;
    assign reg_wr_en   = head.we;
    assign reg_addr    = head.addr;
    assign reg_wr_data = head.data;
    assign reg_ch      = head.ch;
    assign ch_busy     = pend_q | ch_occ;
    assign ch_overrun  = ovr_q;

endmodule

// File: tb/tb_css_mcu0_dmi_req_sync_q.sv
// Directed bench for the DMI request synchronizer/queue (3 channels, depth 2).
module tb_css_mcu0_dmi_req_sync_q;

    localparam int NCH = 3;
    localparam int AW  = 7;
    localparam int DW  = 32;
    localparam int CW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    rd_en = '0;
    logic [NCH-1:0]    wr_en = '0;
    logic [NCH*AW-1:0] wr_addr = '0;
    logic [NCH*DW-1:0] wr_data = '0;
    logic [NCH-1:0]    overrun_clr = '0;
    logic              reg_valid;
    logic              reg_ready = 1'b0;
    logic              reg_wr_en;
    logic [AW-1:0]     reg_addr;
    logic [DW-1:0]     reg_wr_data;
    logic [CW-1:0]     reg_ch;
    logic [NCH-1:0]    ch_busy;
    logic [NCH-1:0]    ch_overrun;

    int checks = 0;
    int errors = 0;
    int nreq;
    int first_ch;

    always #5 clk = ~clk;

    css_mcu0_dmi_req_sync_q #(
        .NUM_CH      (NCH),
        .SYNC_STAGES (3),
        .DEPTH       (2),
        .ADDR_W      (AW),
        .DATA_W      (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .overrun_clr (overrun_clr),
        .reg_valid   (reg_valid),
        .reg_ready   (reg_ready),
        .reg_wr_en   (reg_wr_en),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_ch      (reg_ch),
        .ch_busy     (ch_busy),
        .ch_overrun  (ch_overrun)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        wr_addr[c*AW +: AW] = a;
        wr_data[c*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic check_head(input string tag, input int c,
                              input logic [AW-1:0] a);
        check({tag, "_valid"}, 64'(reg_valid), 64'(1'b1));
        check({tag, "_ch"}, 64'(reg_ch), 64'(c));
        check({tag, "_addr"}, 64'(reg_addr), 64'(a));
    endtask

    // Counts head requests accepted over n cycles, with reg_ready held high.
    task automatic count_reqs(input int n);
        for (int i = 0; i < n; i++) begin
            if (reg_valid) begin
                if (nreq == 0) first_ch = int'(reg_ch);
                nreq++;
            end
            step();
        end
    endtask

    task automatic burst(input string tag);
        rd_en = 3'b111;
        step(5);
        check_head({tag, "_h0"}, 0, 7'h01);
        check({tag, "_busy0"}, 64'(ch_busy), 64'(3'b111));
        step();
        check_head({tag, "_h1"}, 1, 7'h02);
        check({tag, "_busy1"}, 64'(ch_busy), 64'(3'b110));
        step();
        check_head({tag, "_h2"}, 2, 7'h03);
        check({tag, "_busy2"}, 64'(ch_busy), 64'(3'b100));
        step();
        check({tag, "_empty"}, 64'(reg_valid), 64'(1'b0));
        check({tag, "_busy3"}, 64'(ch_busy), 64'(3'b000));
        rd_en = '0;
        step(5);
    endtask

    initial begin
        #1;
        check("rst_valid", 64'(reg_valid), 64'(1'b0));
        check("rst_we", 64'(reg_wr_en), 64'(1'b0));
        check("rst_addr", 64'(reg_addr), 64'(0));
        check("rst_data", 64'(reg_wr_data), 64'(0));
        check("rst_ch", 64'(reg_ch), 64'(0));
        check("rst_busy", 64'(ch_busy), 64'(0));
        check("rst_ovr", 64'(ch_overrun), 64'(0));
        step(2);
        rst = 1'b0;

        // Single write: visible four edges after the sampling edge
        set_req(0, 7'h10, 32'hDEADBEEF);
        reg_ready = 1'b1;
        wr_en[0]  = 1'b1;
        step(4);
        check("lat_early", 64'(reg_valid), 64'(1'b0));
        check("lat_busy", 64'(ch_busy), 64'(3'b001));
        step();
        check_head("lat", 0, 7'h10);
        check("lat_we", 64'(reg_wr_en), 64'(1'b1));
        check("lat_data", 64'(reg_wr_data), 64'(32'hDEADBEEF));
        step();
        check("lat_pop", 64'(reg_valid), 64'(1'b0));
        check("lat_idle", 64'(ch_busy), 64'(3'b000));
        wr_en[0] = 1'b0;
        nreq = 0;
        count_reqs(8);
        check("fall_wr", 64'(nreq), 64'(0));

        // Round robin from reset, then again from pointer 2
        do_reset();
        set_req(0, 7'h01, 32'h0);
        set_req(1, 7'h02, 32'h0);
        set_req(2, 7'h03, 32'h0);
        burst("rr_a");
        burst("rr_b");

        // Depth 2 full with ch2 pending, then overrun on ch2
        do_reset();
        reg_ready = 1'b0;
        rd_en = 3'b111;
        step(7);
        check_head("ovr_pre", 0, 7'h01);
        check("ovr_pre_busy", 64'(ch_busy), 64'(3'b111));
        check("ovr_pre_flag", 64'(ch_overrun), 64'(0));
        rd_en[2] = 1'b0;
        step(5);
        set_req(2, 7'h55, 32'h0);
        rd_en[2] = 1'b1;
        step(5);
        check("ovr_set", 64'(ch_overrun), 64'(3'b100));
        check_head("ovr_hold", 0, 7'h01);
        check("ovr_busy", 64'(ch_busy), 64'(3'b111));
        overrun_clr = 3'b100;
        step();
        overrun_clr = '0;
        check("ovr_clr", 64'(ch_overrun), 64'(0));
        reg_ready = 1'b1;
        step();
        check_head("ovr_q1", 1, 7'h02);
        step();
        check_head("ovr_q2", 2, 7'h03);
        step();
        check("ovr_done", 64'(reg_valid), 64'(1'b0));
        rd_en = '0;
        step(5);

        // Back-pressure, then pop and push in the same cycle
        do_reset();
        reg_ready = 1'b0;
        set_req(0, 7'h21, 32'h11111111);
        set_req(1, 7'h22, 32'h22222222);
        wr_en[0] = 1'b1;
        step(6);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", 64'({reg_valid, reg_wr_en, reg_ch, reg_addr, reg_wr_data}),
                  64'({1'b1, 1'b1, 2'd0, 7'h21, 32'h11111111}));
            step();
        end
        wr_en[1] = 1'b1;
        step(4);
        check_head("bp_a", 0, 7'h21);
        check("bp_busy_a", 64'(ch_busy), 64'(3'b011));
        reg_ready = 1'b1;
        step();
        check_head("bp_b", 1, 7'h22);
        check("bp_b_data", 64'(reg_wr_data), 64'(32'h22222222));
        check("bp_busy_b", 64'(ch_busy), 64'(3'b010));
        step();
        check("bp_cnt", 64'(reg_valid), 64'(1'b0));
        wr_en = '0;
        step(5);

        // rd and wr together resolve to one write; falls are silent
        set_req(0, 7'h33, 32'h33333333);
        rd_en[0] = 1'b1;
        wr_en[0] = 1'b1;
        step(5);
        check_head("rw", 0, 7'h33);
        check("rw_we", 64'(reg_wr_en), 64'(1'b1));
        step();
        check("rw_one", 64'(reg_valid), 64'(1'b0));
        nreq = 0;
        rd_en[0] = 1'b0;
        count_reqs(6);
        wr_en[0] = 1'b0;
        count_reqs(6);
        check("rw_fall", 64'(nreq), 64'(0));

        // Reset with two queued and one pending; rd_en[0] held through it
        reg_ready = 1'b0;
        set_req(0, 7'h01, 32'h0);
        rd_en = 3'b111;
        step(7);
        check("mid_pre", 64'(reg_valid), 64'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        check("mid_valid", 64'(reg_valid), 64'(1'b0));
        check("mid_we", 64'(reg_wr_en), 64'(1'b0));
        check("mid_addr", 64'(reg_addr), 64'(0));
        check("mid_data", 64'(reg_wr_data), 64'(0));
        check("mid_ch", 64'(reg_ch), 64'(0));
        check("mid_busy", 64'(ch_busy), 64'(0));
        rd_en = 3'b001;
        step(2);
        rst = 1'b0;
        reg_ready = 1'b1;
        nreq = 0;
        first_ch = -1;
        count_reqs(12);
        check("post_rst_n", 64'(nreq), 64'(1));
        check("post_rst_ch", 64'(first_ch), 64'(0));
        rd_en = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
